// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg -- definitions shared by the byte-enable dual-port RAM block.
//
// Contents:
//   state_e     : state of the power-up / reset clear sweep (CLEAR, READY)
//   lane_count  : number of byte-enable lanes in a word (DATA_WIDTH/BYTE_WIDTH)
//   DEF_*       : default geometry of the RAM
// ---------------------------------------------------------------------------
package mem_pkg;

   // CLEAR: memory is being zeroed, one word per cycle; all requests ignored.
   // READY: normal read/write service.
   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_e;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_DEPTH      = 32;
   localparam int DEF_BYTE_WIDTH = 8;

   // Lane count for a given geometry; usable in constant expressions.
   function automatic int lane_count(input int data_width, input int byte_width);
      return data_width / byte_width;
   endfunction

   localparam int DEF_LANES = lane_count(DEF_DATA_WIDTH, DEF_BYTE_WIDTH);

endpackage : mem_pkg

// File: rtl/ram_dp_be_if.sv
// ---------------------------------------------------------------------------
// ram_dp_be_if -- request/response bundle of the byte-enable RAM.
//
// Signals:
//   wr_en, wr_addr, wr_data, wr_be : write request (wr_be bit i -> lane i)
//   rd_en, rd_addr                 : read request
//   rd_data, rd_valid              : registered read response (latency 1)
//   busy                           : high while the clear sweep runs
// Modports:
//   master : the requester (drives requests, observes response and busy)
//   slave  : the RAM (receives requests, drives response and busy)
// ---------------------------------------------------------------------------
interface ram_dp_be_if
   import mem_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int BYTE_WIDTH = DEF_BYTE_WIDTH
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int LANES  = lane_count(DATA_WIDTH, BYTE_WIDTH);

   logic                  wr_en;
   logic [ADDR_W-1:0]     wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [LANES-1:0]      wr_be;
   logic                  rd_en;
   logic [ADDR_W-1:0]     rd_addr;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;
   logic                  busy;

   modport master (
      output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
      input  rd_data, rd_valid, busy
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
      output rd_data, rd_valid, busy
   );

endinterface : ram_dp_be_if

// File: rtl/ram_clear_seq.sv
// ---------------------------------------------------------------------------
// ram_clear_seq -- clear-sweep sequencer for ram_dp_be.
//
// After every reset the sequencer walks clr_addr from 0 to DEPTH-1, asking
// the RAM to zero one word per cycle, then moves to READY. busy is high for
// exactly DEPTH cycles after reset is released.
//
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset (restarts the sweep at 0)
//   busy     : sweep in progress; RAM ignores requests while high
//   clr_we   : zero the word at clr_addr on this edge
//   clr_addr : word being zeroed
// ---------------------------------------------------------------------------
module ram_clear_seq
   import mem_pkg::*;
#(
   parameter  int DEPTH  = DEF_DEPTH,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   output logic              busy,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_e            state;
   logic [ADDR_W-1:0] clr_cnt;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the values that existed before the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= CLEAR;
         clr_cnt <= '0;
         busy    <= 1'b1;
      end else begin
         case (state)
            CLEAR: begin
               // Leave only once the last word has been zeroed on this edge.
               if (clr_cnt == LAST_ADDR) begin
                  state   <= READY;
                  busy    <= 1'b0;
                  clr_cnt <= '0;
               end else begin
                  clr_cnt <= clr_cnt + ADDR_W'(1);
               end
            end
            READY: begin
               busy <= 1'b0;
            end
            default: begin
               state   <= CLEAR;
               clr_cnt <= '0;
               busy    <= 1'b1;
            end
         endcase
      end
   end

   // busy is high exactly while in CLEAR, so it doubles as the zeroing strobe.
   assign clr_we   = busy;
   assign clr_addr = clr_cnt;

endmodule : ram_clear_seq

// File: rtl/ram_dp_be.sv
// ---------------------------------------------------------------------------
// ram_dp_be -- simple dual-port RAM with per-lane byte enables.
//
// One write port and one read port sharing clk. Reads have latency 1 and
// produce a one-cycle rd_valid pulse; rd_data holds between reads. After
// reset the array is zeroed by ram_clear_seq; requests are ignored while
// busy. Out-of-range writes are dropped, out-of-range reads return 0.
//
// Configuration macro:
//   RAM_BYPASS_EN : when defined, a read at the address being written in
//                   the same cycle returns the merged new word; otherwise
//                   it returns the old word.
//
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : ram_dp_be_if.slave (wr_*, rd_*, rd_data, rd_valid, busy)
// ---------------------------------------------------------------------------
module ram_dp_be
   import mem_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int BYTE_WIDTH = DEF_BYTE_WIDTH
) (
   input  logic        clk,
   input  logic        rst,
   ram_dp_be_if.slave  bus
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int LANES  = lane_count(DATA_WIDTH, BYTE_WIDTH);
   // One extra bit so DEPTH itself is representable in the range compare.
   localparam logic [ADDR_W:0] DEPTH_EXT = DEPTH[ADDR_W:0];

   logic                  busy;
   logic                  clr_we;
   logic [ADDR_W-1:0]     clr_addr;
   logic                  wr_in_range;
   logic                  rd_in_range;
   logic                  wr_fire;
   logic                  rd_fire;
   logic [DATA_WIDTH-1:0] rd_word;

   // NOTE: the storage array has no reset; it is cleared by the sweep, which
   // keeps it mappable onto block RAM.
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   ram_clear_seq #(
      .DEPTH (DEPTH)
   ) u_clear_seq (
      .clk      (clk),
      .rst      (rst),
      .busy     (busy),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   assign bus.busy    = busy;
   assign wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_EXT);
   assign rd_in_range = ({1'b0, bus.rd_addr} < DEPTH_EXT);
   assign wr_fire     = !rst && !busy && bus.wr_en && wr_in_range;
   assign rd_fire     = !rst && !busy && bus.rd_en;

   // Storage: sweep zeroing has priority; user writes only touch enabled lanes.
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[clr_addr] <= '0;
      end else if (wr_fire) begin
         for (int i = 0; i < LANES; i++) begin
            if (bus.wr_be[i]) begin
               mem[bus.wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <=
                  bus.wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
         end
      end
   end

   // Word presented to the read register this cycle.
   // NOTE: every signal driven here gets a default first, so no latch forms.
   always_comb begin
      rd_word = '0;
      if (rd_in_range) begin
         rd_word = mem[bus.rd_addr];
`ifdef RAM_BYPASS_EN
         // Forward the lanes being written so the read sees the new word.
         if (wr_fire && (bus.wr_addr == bus.rd_addr)) begin
            for (int i = 0; i < LANES; i++) begin
               if (bus.wr_be[i]) begin
                  rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] =
                     bus.wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
               end
            end
         end
`endif
      end
   end

   // Read register: rd_data holds between reads, rd_valid pulses per read.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.rd_data  <= '0;
         bus.rd_valid <= 1'b0;
      end else if (rd_fire) begin
         bus.rd_data  <= rd_word;
         bus.rd_valid <= 1'b1;
      end else begin
         bus.rd_valid <= 1'b0;
      end
   end

endmodule : ram_dp_be

// File: tb/tb_ram_dp_be.sv
// ---------------------------------------------------------------------------
// tb_ram_dp_be -- self-checking bench for ram_dp_be (32 x 32, 8-bit lanes).
// A word-array model applies lane masks arithmetically; directed steps are
// followed by a randomized read/write phase and reset/sweep scenarios.
// ---------------------------------------------------------------------------
module tb_ram_dp_be;

   localparam int DW    = 32;
   localparam int DEPTH = 32;
   localparam int BW    = 8;
   localparam int AW    = 5;
   localparam int LANES = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ram_dp_be_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .BYTE_WIDTH(BW)) bus ();

   ram_dp_be #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .BYTE_WIDTH(BW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [DW-1:0] model [DEPTH];
   logic [DW-1:0] last_rd;
   int passed = 0;
   int total  = 0;

   task automatic check(input string tag, input logic [DW-1:0] obs,
                        input logic [DW-1:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // New word after writing data into old under the given lane enables.
   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                           input logic [DW-1:0] data,
                                           input logic [LANES-1:0] be);
      logic [DW-1:0] mask;
      mask = '0;
      for (int i = 0; i < LANES; i++)
         if (be[i]) mask = mask | (32'h0000_00FF << (BW * i));
      return (old & ~mask) | (data & mask);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.wr_en   = 1'b0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      bus.wr_be   = '0;
      bus.rd_en   = 1'b0;
      bus.rd_addr = '0;
   endtask

   // One READY cycle: optional write and optional read, checked against model.
   task automatic cycle(input string tag, input logic we, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input logic [LANES-1:0] be,
                        input logic re, input logic [AW-1:0] ra);
      logic [DW-1:0] exp_rd;
      bus.wr_en   = we;
      bus.wr_addr = wa;
      bus.wr_data = wd;
      bus.wr_be   = be;
      bus.rd_en   = re;
      bus.rd_addr = ra;
      exp_rd = model[ra];
`ifdef RAM_BYPASS_EN
      if (we && wa == ra) exp_rd = merge(model[ra], wd, be);
`endif
      if (we) model[wa] = merge(model[wa], wd, be);
      tick();
      idle_inputs();
      if (re) begin
         check({tag, ".valid"}, 32'(bus.rd_valid), 32'd1);
         check({tag, ".data"}, bus.rd_data, exp_rd);
         last_rd = exp_rd;
      end else begin
         check({tag, ".novalid"}, 32'(bus.rd_valid), 32'd0);
         check({tag, ".hold"}, bus.rd_data, last_rd);
      end
   endtask

   // Count busy cycles after reset release (bounded); stray rd_valid counted.
   task automatic count_busy(output int n, output int stray);
      n = 0;
      stray = 0;
      while (bus.busy && n < 100) begin
         n++;
         if (bus.rd_valid) stray++;
         tick();
      end
   endtask

   int n_busy;
   int n_stray;

   initial begin
      idle_inputs();
      last_rd = '0;

      // ---- reset and initial sweep ----
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst.rd_valid", 32'(bus.rd_valid), 32'd0);
      check("rst.rd_data", bus.rd_data, 32'd0);
      check("rst.busy", 32'(bus.busy), 32'd1);
      count_busy(n_busy, n_stray);
      check("sweep.busy_cycles", n_busy, 32'd32);
      for (int a = 0; a < DEPTH; a++) model[a] = '0;
      for (int a = 0; a < DEPTH; a++) cycle("zero_rd", 1'b0, '0, '0, '0, 1'b1, AW'(a));

      // ---- directed writes with byte enables ----
      cycle("wr5", 1'b1, 5'd5, 32'hDEAD_BEEF, 4'hF, 1'b0, '0);
      cycle("rd5", 1'b0, '0, '0, '0, 1'b1, 5'd5);
      check("rd5.const", bus.rd_data, 32'hDEAD_BEEF);
      cycle("wr5_be2", 1'b1, 5'd5, 32'h0000_AA00, 4'h2, 1'b0, '0);
      cycle("rd5_be2", 1'b0, '0, '0, '0, 1'b1, 5'd5);
      check("rd5_be2.const", bus.rd_data, 32'hDEAD_AAEF);
      cycle("wr5_be0", 1'b1, 5'd5, 32'hFFFF_FFFF, 4'h0, 1'b0, '0);
      cycle("rd5_be0", 1'b0, '0, '0, '0, 1'b1, 5'd5);
      check("rd5_be0.const", bus.rd_data, 32'hDEAD_AAEF);

      // ---- same-cycle read and write at one address ----
      cycle("rdw7", 1'b1, 5'd7, 32'h1234_5678, 4'hF, 1'b1, 5'd7);
`ifdef RAM_BYPASS_EN
      check("rdw7.const", bus.rd_data, 32'h1234_5678);
`else
      check("rdw7.const", bus.rd_data, 32'h0000_0000);
`endif
      cycle("rd7", 1'b0, '0, '0, '0, 1'b1, 5'd7);
      check("rd7.const", bus.rd_data, 32'h1234_5678);

      // ---- back-to-back reads at the address extremes ----
      cycle("wr31", 1'b1, 5'd31, 32'hA5A5_0031, 4'hF, 1'b0, '0);
      cycle("wr0", 1'b1, 5'd0, 32'h5A5A_0000, 4'hF, 1'b0, '0);
      cycle("b2b31", 1'b0, '0, '0, '0, 1'b1, 5'd31);
      cycle("b2b0", 1'b0, '0, '0, '0, 1'b1, 5'd0);
      cycle("b2b_idle", 1'b0, '0, '0, '0, 1'b0, '0);

      // ---- randomized traffic ----
      for (int k = 0; k < 300; k++) begin
         cycle("rand", 1'($urandom), AW'($urandom), DW'($urandom),
               LANES'($urandom), 1'($urandom), AW'($urandom_range(0, 7)));
      end

      // ---- reset during READY with a read in flight ----
      cycle("wr3", 1'b1, 5'd3, 32'h0000_0055, 4'hF, 1'b0, '0);
      bus.rd_en   = 1'b1;
      bus.rd_addr = 5'd3;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      idle_inputs();
      check("rst_rd.valid", 32'(bus.rd_valid), 32'd0);
      check("rst_rd.data", bus.rd_data, 32'd0);

      // ---- reset again on sweep cycle 10 ----
      for (int k = 0; k < 10; k++) tick();
      check("sweep10.busy", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.wr_en   = 1'b1;
      bus.wr_addr = 5'd3;
      bus.wr_data = 32'hFFFF_FFFF;
      bus.wr_be   = 4'hF;
      bus.rd_en   = 1'b1;
      bus.rd_addr = 5'd3;
      count_busy(n_busy, n_stray);
      idle_inputs();
      check("restart.busy_cycles", n_busy, 32'd32);
      check("restart.stray_valid", n_stray, 32'd0);
      check("restart.post_valid", 32'(bus.rd_valid), 32'd0);
      for (int a = 0; a < DEPTH; a++) model[a] = '0;
      last_rd = '0;
      cycle("rd3_after", 1'b0, '0, '0, '0, 1'b1, 5'd3);
      check("rd3_after.const", bus.rd_data, 32'd0);
      cycle("rd31_after", 1'b0, '0, '0, '0, 1'b1, 5'd31);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule : tb_ram_dp_be

// File: doc/ram_dp_be.md
RAM_DP_BE -- requirements
Module: ram_dp_be

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: word width in bits; must be a multiple of BYTE_WIDTH.
REQ-002 SHALL have parameter DEPTH, default 32: number of words, 2 or more; need not be a power of two.
REQ-003 SHALL have parameter BYTE_WIDTH, default 8: lane width covered by one byte-enable bit.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port wr_en, input, 1: write request.
REQ-007 SHALL have port wr_addr, input, $clog2(DEPTH): write word address.
REQ-008 SHALL have port wr_data, input, DATA_WIDTH: write data.
REQ-009 SHALL have port wr_be, input, DATA_WIDTH/BYTE_WIDTH: per-lane write enable; bit i covers lane i, LSB lane is bit 0.
REQ-010 SHALL have port rd_en, input, 1: read request.
REQ-011 SHALL have port rd_addr, input, $clog2(DEPTH): read word address.
REQ-012 SHALL have port rd_data, output, DATA_WIDTH: registered read data.
REQ-013 SHALL have port rd_valid, output, 1: one-cycle pulse qualifying rd_data.
REQ-014 SHALL have port busy, output, 1: high while the clear sweep runs.

Function
REQ-015 SHALL use a 2-state FSM: CLEAR and READY.
REQ-016 SHALL go from CLEAR to READY only after the word at DEPTH-1 is zeroed.
REQ-017 In CLEAR, SHALL zero one word per cycle, addresses 0 to DEPTH-1 via clr_cnt; busy is 1 for exactly DEPTH cycles after rst deasserts.
REQ-018 While busy, SHALL ignore wr_en and rd_en; no pending effect remains.
REQ-019 In READY with wr_en=1, SHALL write only the lanes whose wr_be bit is 1 on that edge; other lanes keep their value.
REQ-020 SHALL treat wr_be all zero as a no-op.
REQ-021 In READY with rd_en=1, SHALL put the word at rd_addr on rd_data and assert rd_valid on the next cycle (latency 1).
REQ-022 SHALL hold rd_data when rd_en=0; rd_valid SHALL be 0 then.
REQ-023 Back-to-back reads SHALL give one result per cycle.
REQ-024 SHALL allow a read and a write in the same cycle.
REQ-025 For same-cycle read and write at one address, without RAM_BYPASS_EN, SHALL return the pre-write (old) word.
REQ-026 SHALL drop writes with an address of DEPTH or more.
REQ-027 For a read with an address of DEPTH or more, SHALL return 0 with rd_valid=1.

Reset
REQ-028 When rst=1 on a clock edge, SHALL set: state=CLEAR, clr_cnt=0, busy=1, rd_data=0, rd_valid=0.
REQ-029 A reset during CLEAR SHALL restart the sweep at address 0.
REQ-030 A reset during READY SHALL drop any read in flight; no rd_valid is produced for it.

Configuration
REQ-031 Macro RAM_BYPASS_EN SHALL control read-during-write forwarding.
REQ-032 With RAM_BYPASS_EN defined, a same-address read SHALL return the word after the write: written lanes from wr_data, other lanes from memory.
REQ-033 Without RAM_BYPASS_EN, SHALL have no forwarding logic; REQ-025 applies.

Structure
REQ-034 SHALL place the FSM state enum (CLEAR, READY) in shared package mem_pkg.
REQ-035 SHALL place the helper constant for lane count (DATA_WIDTH/BYTE_WIDTH) in mem_pkg.
REQ-036 SHALL put the sweep counter and FSM in one sub-module, ram_clear_seq, with outputs busy, clr_we and clr_addr.
REQ-037 SHALL keep the storage array and read path in ram_dp_be.

Verification (DATA_WIDTH=32, DEPTH=32, BYTE_WIDTH=8)
REQ-038 rst high 1 cycle, then low -> busy=1 for exactly 32 cycles; then reading addresses 0..31 returns 0x00000000.
REQ-039 Write 0xDEADBEEF to addr 5 with be=0xF; next cycle read addr 5 -> one cycle later rd_data=0xDEADBEEF and rd_valid=1.
REQ-040 Then write 0x0000AA00 to addr 5 with be=0x2; read addr 5 -> 0xDEADAAEF.
REQ-041 Same cycle: write 0x12345678 (be=0xF) and read at addr 7, which holds 0 -> 0x00000000 without the macro, 0x12345678 with RAM_BYPASS_EN; a later read returns 0x12345678.
REQ-042 Reset on sweep cycle 10 -> busy stays 1 for 32 more cycles; a write to addr 3 during busy is dropped, and addr 3 reads 0.
REQ-043 Read addr 31 then addr 0 on consecutive cycles -> two consecutive rd_valid pulses with the matching data.
